// File: rtl/input_ddr_align_ctrl_if.sv
// Bus between the I_DDR word aligner and its user: DDR sample pair and training
// controls in, aligned words and training status out.
interface input_ddr_align_ctrl_if #(
   parameter int WORD_WIDTH = 8
);
   localparam int SLIP_WIDTH = $clog2(WORD_WIDTH);

   logic [1:0]            ddr_in;
   logic                  train_en;
   logic                  clear;
   logic                  ddr_en;
   logic [WORD_WIDTH-1:0] word;
   logic                  word_valid;
   logic                  locked;
   logic                  train_fail;
   logic [SLIP_WIDTH-1:0] slip_offset;

   modport master (
      output ddr_in, train_en, clear,
      input  ddr_en, word, word_valid, locked, train_fail, slip_offset
   );

   modport slave (
      input  ddr_in, train_en, clear,
      output ddr_en, word, word_valid, locked, train_fail, slip_offset
   );
endinterface

// File: rtl/input_ddr_align_ctrl.sv
// Bit-slip word aligner for an I_DDR input: trains on a known pattern by sliding
// the word window one bit per word period, then streams aligned words once locked.
module input_ddr_align_ctrl #(
   parameter int                    WORD_WIDTH    = 8,
   parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
   parameter int                    LOCK_COUNT    = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input_ddr_align_ctrl_if.slave       bus
);

   localparam int SW = $clog2(WORD_WIDTH);
   localparam int HW = 2 * WORD_WIDTH;
   localparam int PW = $clog2(WORD_WIDTH / 2) > 0 ? $clog2(WORD_WIDTH / 2) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(WORD_WIDTH / 2 - 1);
   localparam logic [SW-1:0] SLIP_LAST  = SW'(WORD_WIDTH - 1);
   localparam logic [SW:0]   TRIES_LAST = (SW + 1)'(WORD_WIDTH - 1);
   localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_COUNT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_CHECK,
      ST_LOCKED,
      ST_FAIL
   } state_t;

   state_t                state_q, state_d;
   logic [HW-1:0]         h_q, h_d;
   logic [PW-1:0]         phase_q;
   logic [SW-1:0]         slip_q, slip_d, slip_inc;
   logic [3:0]            match_q, match_d, match_inc;
   logic [SW:0]           tries_q, tries_d;
   logic [WORD_WIDTH-1:0] cand, word_q;
   logic                  boundary, hit, emit;
   logic                  valid_q, locked_q, fail_q, ddr_en_q;

   // Candidate is taken from the history as it will look after this cycle's shift.
   always_comb begin
      h_d = {h_q[HW-3:0], bus.ddr_in[0], bus.ddr_in[1]};
      cand = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         cand[i] = h_d[i + int'(slip_q)];
      end
   end

   assign boundary  = (phase_q == PHASE_LAST);
   assign hit       = (cand == TRAIN_PATTERN);
   assign slip_inc  = (slip_q == SLIP_LAST) ? '0 : slip_q + 1'b1;
   assign match_inc = (state_q == ST_SEARCH) ? 4'd1 : match_q + 4'd1;
   assign emit      = (state_q == ST_LOCKED) && boundary && !bus.clear;

   // State and training counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         slip_q  <= '0;
         match_q <= '0;
         tries_q <= '0;
      end else begin
         state_q <= state_d;
         slip_q  <= slip_d;
         match_q <= match_d;
         tries_q <= tries_d;
      end
   end

   // Clear beats everything; dropping train_en beats any boundary decision.
   always_comb begin
      state_d = state_q;
      slip_d  = slip_q;
      match_d = match_q;
      tries_d = tries_q;
      if (bus.clear) begin
         state_d = ST_IDLE;
         slip_d  = '0;
         match_d = '0;
         tries_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.train_en) begin
                  state_d = ST_SEARCH;
                  slip_d  = '0;
                  match_d = '0;
                  tries_d = '0;
               end
            end
            ST_SEARCH, ST_CHECK: begin
               if (!bus.train_en) begin
                  state_d = ST_IDLE;
               end else if (boundary) begin
                  if (hit) begin
                     match_d = match_inc;
                     state_d = (match_inc == LOCK_TARGET) ? ST_LOCKED : ST_CHECK;
                  end else begin
                     slip_d = slip_inc;
                     if (state_q == ST_CHECK) begin
                        state_d = ST_SEARCH;
                     end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_q == TRIES_LAST) begin
                           state_d = ST_FAIL;
                        end
                     end
                  end
               end
            end
            ST_FAIL: begin
               if (!bus.train_en) begin
                  state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Sample history, word phase and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q      <= '0;
         phase_q  <= '0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         fail_q   <= 1'b0;
         ddr_en_q <= 1'b0;
      end else begin
         h_q      <= h_d;
         phase_q  <= boundary ? '0 : phase_q + 1'b1;
         valid_q  <= emit;
         locked_q <= (state_d == ST_LOCKED);
         fail_q   <= (state_d == ST_FAIL);
         ddr_en_q <= (state_d != ST_IDLE);
         if (emit) begin
            word_q <= cand;
         end
      end
   end

   assign bus.ddr_en      = ddr_en_q;
   assign bus.word        = word_q;
   assign bus.word_valid  = valid_q;
   assign bus.locked      = locked_q;
   assign bus.train_fail  = fail_q;
   assign bus.slip_offset = slip_q;

endmodule

// File: doc/input_ddr_align_ctrl.md
INPUT_DDR_ALIGN_CTRL -- requirements
Module: input_ddr_align_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, default 8: deserialized word width; SHALL be even, range 4..32.
REQ-002 Parameter TRAIN_PATTERN, default 8'hA5: WORD_WIDTH-bit training word.
REQ-003 Parameter LOCK_COUNT, default 4: consecutive pattern matches required for lock; range 1..15.
REQ-004 CLK  in  1  single clock; same clock that drives the I_DDR C pin.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 DDR_IN  in  2  I_DDR Q; bit0 = rising-edge sample (older), bit1 = falling-edge sample (newer).
REQ-007 TRAIN_EN  in  1  level; requests alignment training.
REQ-008 CLEAR  in  1  synchronous pulse; abandons training or lock.
REQ-009 DDR_EN  out  1  drives I_DDR E pin.
REQ-010 WORD  out  WORD_WIDTH  aligned word, MSB = oldest bit.
REQ-011 WORD_VALID  out  1  one-cycle strobe; WORD is valid in this cycle.
REQ-012 LOCKED  out  1  alignment achieved.
REQ-013 TRAIN_FAIL  out  1  sticky; no offset matched.
REQ-014 SLIP_OFFSET  out  clog2(WORD_WIDTH)  current bit-slip offset.

Function
REQ-015 History register H (2*WORD_WIDTH bits) SHALL shift every cycle: H <= {H[2W-3:0], DDR_IN[0], DDR_IN[1]}.
REQ-016 Phase counter SHALL run 0..W/2-1 continuously from reset release; word boundary = cycle in which counter equals W/2-1.
REQ-017 Candidate word SHALL be H[W-1+S:S], S = SLIP_OFFSET, sampled at the word boundary using H after that cycle's shift.
REQ-018 FSM states IDLE, SEARCH, CHECK, LOCKED, FAIL; reset state IDLE.
REQ-019 IDLE: TRAIN_EN=1 -> SEARCH, with S=0 and match count 0.
REQ-020 SEARCH, at word boundary: candidate==TRAIN_PATTERN -> CHECK, count=1 (if LOCK_COUNT=1 -> LOCKED directly); mismatch -> S=S+1 mod W, with slip-attempt counter incremented.
REQ-021 SEARCH: W consecutive mismatches (all offsets tried) -> FAIL.
REQ-022 CHECK, at word boundary: match -> count+1; count reaching LOCK_COUNT -> LOCKED; mismatch -> SEARCH with S=S+1 mod W; slip-attempt counter continues (not reset).
REQ-023 SEARCH/CHECK/FAIL: TRAIN_EN=0 -> IDLE; S is held.
REQ-024 LOCKED SHALL ignore TRAIN_EN and hold S.
REQ-025 CLEAR=1 from any state -> IDLE next cycle, S=0, TRAIN_FAIL=0; CLEAR takes priority over all other transitions in the same cycle.
REQ-026 Offset change SHALL take effect at the next word boundary; no wait cycles are inserted.
REQ-027 In LOCKED, the block SHALL register WORD at each word boundary and pulse WORD_VALID for exactly one cycle, one cycle after the boundary.
REQ-028 Outside LOCKED, WORD_VALID SHALL be 0 and WORD SHALL hold its last value.
REQ-029 DDR_EN SHALL be 0 in IDLE and 1 in all other states.
REQ-030 LOCKED output SHALL be 1 exactly while the FSM is in LOCKED; TRAIN_FAIL SHALL be 1 exactly while the FSM is in FAIL.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 RST_N=0 SHALL immediately force: state IDLE, H=0, phase=0, S=0, counts=0, WORD=0, WORD_VALID=0, LOCKED=0, TRAIN_FAIL=0, DDR_EN=0.
REQ-033 RST_N asserted mid-training or while LOCKED SHALL give the same values as REQ-032; after reset release, operation SHALL restart from IDLE.

Verification (W=8, TRAIN_PATTERN=8'hA5, LOCK_COUNT=4)
REQ-034 Stream of repeated A5, word-aligned; TRAIN_EN=1 -> SLIP_OFFSET=0, LOCKED=1 after the 4th boundary, then WORD_VALID every 4 cycles with WORD=8'hA5.
REQ-035 Same stream delayed by 3 bits -> LOCKED with SLIP_OFFSET equal to the unique offset that yields A5, reached within 8+4 word periods; WORD=8'hA5.
REQ-036 Constant 2'b00 input, TRAIN_EN=1 -> TRAIN_FAIL=1 after 8 word boundaries (32 cycles), DDR_EN=1; TRAIN_EN=0 -> IDLE with TRAIN_FAIL=0.
REQ-037 Aligned A5 stream with one corrupted word after 2 matches -> return to SEARCH, S incremented; LOCKED only after 4 fresh consecutive matches.
REQ-038 LOCKED, then CLEAR pulse with TRAIN_EN=1 held -> IDLE for one cycle, S=0, LOCKED=0, then SEARCH.
REQ-039 RST_N pulsed low during CHECK -> all outputs at reset values asynchronously; relock succeeds after release.
